serial_compare_ctrl: RTL and testbench



---
 rtl/serial_compare_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_compare_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/serial_compare_ctrl.sv
// Bit-serial magnitude comparator: one shared compare slice walks both
// operands LSB to MSB over N cycles and registers a one-hot eq/gt/lt result.

module cmp_bit_slice (
    input  logic i_a,
    input  logic i_b,
    input  logic i_e,
    input  logic i_g,
    output logic o_e,
    output logic o_g
);
    logic w_same;

    assign w_same = ~(i_a ^ i_b);
    assign o_e    = i_e & w_same;
    assign o_g    = (i_a & ~i_b) | (w_same & i_g);
endmodule

module serial_compare_ctrl #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         eq,
    output logic         gt,
    output logic         lt
);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_sa;
    logic [N-1:0]    r_sb;
    logic [CW-1:0]   r_cnt;
    logic            r_e;
    logic            r_g;
    logic            r_busy;
    logic            r_done;
    logic            r_eq;
    logic            r_gt;
    logic            r_lt;

    logic            w_e1;
    logic            w_g1;

    // Single shared slice; cascade state is carried in r_e / r_g between cycles.
    cmp_bit_slice u_slice (
        .i_a (r_sa[0]),
        .i_b (r_sb[0]),
        .i_e (r_e),
        .i_g (r_g),
        .o_e (w_e1),
        .o_g (w_g1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_cnt   <= '0;
            r_e     <= 1'b1;
            r_g     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_e     <= 1'b1;
                        r_g     <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_e  <= w_e1;
                    r_g  <= w_g1;
                    r_sa <= {1'b0, r_sa[N-1:1]};
                    r_sb <= {1'b0, r_sb[N-1:1]};
                    if (r_cnt == LAST) begin
                        // Final (MSB) bit: publish result and free the slice.
                        r_cnt   <= '0;
                        r_eq    <= w_e1;
                        r_gt    <= w_g1;
                        r_lt    <= ~w_e1 & ~w_g1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign eq   = r_eq;
    assign gt   = r_gt;
    assign lt   = r_lt;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Self-checking bench for serial_compare_ctrl: directed cases plus 256
// back-to-back random operand pairs checked against an arithmetic model.

module tb_serial_compare_ctrl;
    localparam int unsigned N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic         eq;
    logic         gt;
    logic         lt;

    int n_cmp = 0;
    int n_err = 0;

    // Last published result; all zero until the first completion.
    logic [2:0] prev_res = 3'b000;

    serial_compare_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .eq    (eq),
        .gt    (gt),
        .lt    (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Enters and leaves at a falling edge. inj > 0 pulses a (to be ignored)
    // start with FF/00 operands in run cycle inj.
    task automatic run_cmp(input logic [N-1:0] x, input logic [N-1:0] y, input int inj);
        logic [2:0] exp_res;
        exp_res = {(x == y), (x > y), (x < y)};
        start = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        chk("busy_acc", busy, 1);
        chk("done_acc", done, 0);
        chk("hold_acc", {eq, gt, lt}, prev_res);
        a = N'($urandom);
        b = N'($urandom);
        for (int k = 1; k < int'(N); k++) begin
            if (k == inj) begin
                start = 1'b1;
                a = 8'hFF;
                b = 8'h00;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            chk("hold_run", {eq, gt, lt}, prev_res);
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_end", done, 1);
        chk("busy_end", busy, 0);
        chk("eq", eq, exp_res[2]);
        chk("gt", gt, exp_res[1]);
        chk("lt", lt, exp_res[0]);
        prev_res = exp_res;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] x;
        logic [N-1:0] y;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", {busy, done, eq, gt, lt}, 5'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", {busy, done}, 2'b0);

        run_cmp(8'hA5, 8'hA5, 0);
        run_cmp(8'h80, 8'h7F, 0);
        run_cmp(8'h01, 8'h80, 0);
        run_cmp(8'h10, 8'h20, 3);
        // Start asserted during the done cycle: accepted with no idle gap.
        run_cmp(8'hFF, 8'h00, 0);

        // Abort mid-compare with asynchronous reset.
        start = 1'b1;
        a = 8'h55;
        b = 8'h12;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_now", {busy, done, eq, gt, lt}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        prev_res = 3'b000;
        for (int k = 0; k < int'(N) + 2; k++) begin
            @(negedge clk);
            chk("abort_quiet", {busy, done, eq, gt, lt}, 5'b0);
        end
        run_cmp(8'h3C, 8'h3C, 0);

        // Back-to-back random pairs; about a quarter forced equal.
        for (int i = 0; i < 256; i++) begin
            x = N'($urandom);
            y = ($urandom_range(3) == 0) ? x : N'($urandom);
            run_cmp(x, y, 0);
        end

        @(negedge clk);
        chk("done_single", done, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
